// File: rtl/dvp_pkg.sv
// Shared DVP state encoding and default timing, used by the transmitter and camera-side blocks.
package dvp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    LBLANK = 2'd2,
    ACTIVE = 2'd3
  } dvp_state_t;

  localparam int DVP_H_ACTIVE = 640;
  localparam int DVP_V_ACTIVE = 360;
  localparam int DVP_H_BLANK  = 16;
  localparam int DVP_VS_LOW   = 64;
  localparam int DVP_PCLK_DIV = 4;

  function automatic int dvp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_if.sv
// Pixel source handshake plus camera-side DVP pins of the transmitter.
interface dvp_if;

  logic       pixel_valid_in;
  logic [7:0] pixel_data_in;
  logic       pixel_ready_out;
  logic       camera_pclk_out;
  logic       camera_hs_out;
  logic       camera_vs_out;
  logic [7:0] camera_data_out;

  modport master (
    input  pixel_valid_in, pixel_data_in,
    output pixel_ready_out, camera_pclk_out, camera_hs_out, camera_vs_out, camera_data_out
  );

  modport slave (
    output pixel_valid_in, pixel_data_in,
    input  pixel_ready_out, camera_pclk_out, camera_hs_out, camera_vs_out, camera_data_out
  );

endinterface

// File: rtl/dvp_pclk_gen.sv
// Free-running pixel clock divider: low half-period first, then high.
// fall_tick marks the cycle before pclk drops; pre_fall_tick the cycle before that.
module dvp_pclk_gen #(
  parameter int PCLK_DIV = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic pclk_out,
  output logic fall_tick_out,
  output logic pre_fall_tick_out
);

  localparam int CW   = $clog2(PCLK_DIV);
  localparam int HALF = PCLK_DIV / 2;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_pclk;

  always_comb begin
    w_cnt_nxt = (r_cnt == CW'(PCLK_DIV - 1)) ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt  <= '0;
      r_pclk <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_pclk <= (w_cnt_nxt >= CW'(HALF));
    end
  end

  assign pclk_out          = r_pclk;
  assign fall_tick_out     = (r_cnt == CW'(PCLK_DIV - 1));
  assign pre_fall_tick_out = (r_cnt == CW'(PCLK_DIV - 2));

endmodule

// File: rtl/dvp_transmitter.sv
// DVP frame generator: vs/hs/data move only with pclk falling; one byte pulled per active period.
// The source is never stalled: a missing byte goes out as 0x00 and sets the sticky underflow flag.
module dvp_transmitter
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = DVP_H_ACTIVE,
  parameter int V_ACTIVE = DVP_V_ACTIVE,
  parameter int H_BLANK  = DVP_H_BLANK,
  parameter int VS_LOW   = DVP_VS_LOW,
  parameter int PCLK_DIV = DVP_PCLK_DIV
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  enable_in,
  dvp_if.master dvp,
  output logic  frame_start_out,
  output logic  underflow_out
);

  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam int BW = $clog2(dvp_max(H_BLANK, VS_LOW) + 1);

  logic w_fall_tick;
  logic w_pre_fall_tick;

  dvp_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk_gen (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .pclk_out          (dvp.camera_pclk_out),
    .fall_tick_out     (w_fall_tick),
    .pre_fall_tick_out (w_pre_fall_tick)
  );

  dvp_state_t    r_state, w_state_nxt;
  logic [BW-1:0] r_blank, w_blank_nxt;
  logic [PW-1:0] r_pix, w_pix_nxt;
  logic [LW-1:0] r_line, w_line_nxt;
  logic          r_hs, w_hs_nxt;
  logic          r_vs, w_vs_nxt;
  logic          w_fs_nxt;
  logic [7:0]    r_data;
  logic          r_ready;
  logic          r_frame_start;
  logic          r_underflow;
  logic          w_blank_last;
  logic          w_take;

  // State only advances on fall_tick, so w_take is already valid one cycle early for the ready strobe.
  always_comb begin
    w_blank_last = (r_state == VBLANK) ? (r_blank == BW'(VS_LOW - 1))
                                       : (r_blank == BW'(H_BLANK - 1));
    w_take = 1'b0;
    if (r_state == LBLANK && w_blank_last && r_line != LW'(V_ACTIVE)) w_take = 1'b1;
    if (r_state == ACTIVE && r_pix != PW'(H_ACTIVE))                  w_take = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_blank_nxt = r_blank;
    w_pix_nxt   = r_pix;
    w_line_nxt  = r_line;
    w_hs_nxt    = r_hs;
    w_vs_nxt    = r_vs;
    w_fs_nxt    = 1'b0;
    if (w_fall_tick) begin
      unique case (r_state)
        IDLE: begin
          if (enable_in) begin
            w_state_nxt = VBLANK;
            w_blank_nxt = '0;
          end
        end
        VBLANK: begin
          if (w_blank_last) begin
            w_state_nxt = LBLANK;
            w_blank_nxt = '0;
            w_line_nxt  = '0;
            w_vs_nxt    = 1'b1;
            w_fs_nxt    = 1'b1;
          end else begin
            w_blank_nxt = r_blank + 1'b1;
          end
        end
        LBLANK: begin
          if (!w_blank_last) begin
            w_blank_nxt = r_blank + 1'b1;
          end else if (w_take) begin
            w_state_nxt = ACTIVE;
            w_pix_nxt   = PW'(1);
            w_hs_nxt    = 1'b1;
          end else begin
            // Trailing blank done: the frame ends here and enable_in decides what follows.
            w_vs_nxt    = 1'b0;
            w_blank_nxt = '0;
            w_state_nxt = enable_in ? VBLANK : IDLE;
          end
        end
        ACTIVE: begin
          if (w_take) begin
            w_pix_nxt = r_pix + 1'b1;
          end else begin
            w_state_nxt = LBLANK;
            w_blank_nxt = '0;
            w_pix_nxt   = '0;
            w_hs_nxt    = 1'b0;
            w_line_nxt  = r_line + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= IDLE;
      r_blank       <= '0;
      r_pix         <= '0;
      r_line        <= '0;
      r_hs          <= 1'b0;
      r_vs          <= 1'b0;
      r_data        <= 8'h00;
      r_ready       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_blank       <= w_blank_nxt;
      r_pix         <= w_pix_nxt;
      r_line        <= w_line_nxt;
      r_hs          <= w_hs_nxt;
      r_vs          <= w_vs_nxt;
      r_frame_start <= w_fs_nxt;
      r_ready       <= w_pre_fall_tick && w_take;
      if (r_ready) begin
        r_data <= dvp.pixel_valid_in ? dvp.pixel_data_in : 8'h00;
        if (!dvp.pixel_valid_in) r_underflow <= 1'b1;
      end else if (w_fall_tick) begin
        r_data <= 8'h00;
      end
    end
  end

  assign dvp.pixel_ready_out = r_ready;
  assign dvp.camera_hs_out   = r_hs;
  assign dvp.camera_vs_out   = r_vs;
  assign dvp.camera_data_out = r_data;
  assign frame_start_out     = r_frame_start;
  assign underflow_out       = r_underflow;

endmodule

// File: doc/dvp_transmitter.md
DVP_TRANSMITTER -- requirements
Module: dvp_transmitter

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels (bytes) per line; must be >= 1.
REQ-002 Parameter V_ACTIVE, 360, active lines per frame; must be >= 1.
REQ-003 Parameter H_BLANK, 16, pclk periods with hs low before each line, plus one trailing blank after the last line; must be >= 1.
REQ-004 Parameter VS_LOW, 64, pclk periods with vs low between frames; must be >= 1.
REQ-005 Parameter PCLK_DIV, 4, clk_in cycles per pclk period; must be even and >= 2.
REQ-006 Clock and reset: one clock, clk_in; reset rst_in is synchronous and active-high.
REQ-007 Port clk_in, input, 1, system clock.
REQ-008 Port rst_in, input, 1, synchronous active-high reset.
REQ-009 Port enable_in, input, 1, request frame generation; sampled only at frame boundaries.
REQ-010 Port pixel_valid_in, input, 1, pixel_data_in holds a valid byte.
REQ-011 Port pixel_data_in, input, 8, next luminance byte to send.
REQ-012 Port pixel_ready_out, output, 1, single-cycle pulse: byte on pixel_data_in is consumed this cycle.
REQ-013 Port camera_pclk_out, output, 1, generated pixel clock.
REQ-014 Port camera_hs_out, output, 1, high during active pixels of a line.
REQ-015 Port camera_vs_out, output, 1, high for the whole frame body, low during vertical blanking.
REQ-016 Port camera_data_out, output, 8, pixel byte.
REQ-017 Port frame_start_out, output, 1, single-cycle pulse on the cycle camera_vs_out rises.
REQ-018 Port underflow_out, output, 1, sticky: a byte was needed while pixel_valid_in was low.

Function
REQ-019 pclk period: low for PCLK_DIV/2 clk_in cycles, then high for PCLK_DIV/2; free-runs in every state after reset.
REQ-020 camera_hs_out, camera_vs_out, and camera_data_out shall change only on the clk_in cycle where camera_pclk_out goes 1->0, so they are stable across every rising edge.
REQ-021 States are IDLE, VBLANK, LBLANK, ACTIVE; each state lasts a whole number of pclk periods.
REQ-022 IDLE: vs=0, hs=0, data=0; at a pclk falling edge with enable_in=1, go to VBLANK.
REQ-023 VBLANK lasts VS_LOW periods with vs=0 and hs=0, then goes to LBLANK with vs rising and frame_start_out pulsing.
REQ-024 LBLANK lasts H_BLANK periods with vs=1, hs=0, data=0.
REQ-025 After LBLANK, go to ACTIVE if lines sent < V_ACTIVE; otherwise drop vs and go to VBLANK if enable_in=1, else IDLE.
REQ-026 ACTIVE lasts H_ACTIVE periods with vs=1 and hs=1, one byte per period, then goes to LBLANK and increments the line count.
REQ-027 Frame body with vs high = V_ACTIVE*(H_BLANK+H_ACTIVE)+H_BLANK pclk periods.
REQ-028 The vs rising edge lands on a pclk boundary where hs=0, so a receiver sampling on the pclk rising edge counts exactly V_ACTIVE hs falling edges per frame.
REQ-029 pixel_ready_out is high for exactly one clk_in cycle, the cycle before each ACTIVE period's falling edge; the sampled byte appears on camera_data_out on the next cycle.
REQ-030 If pixel_valid_in=0 when pixel_ready_out=1, send 8'h00 and set underflow_out; pixel order and timing are unchanged.
REQ-031 enable_in falling mid-frame completes the current frame, including the trailing blank, then goes to IDLE; frames are never truncated.
REQ-032 Pixel counter width is $clog2(H_ACTIVE+1) and line counter width is $clog2(V_ACTIVE+1); counters never wrap within a frame.

Reset
REQ-033 While rst_in=1: state IDLE, all counters 0, camera_pclk_out=0, hs=0, vs=0, data=0, pixel_ready_out=0, frame_start_out=0, underflow_out=0.
REQ-034 Reset mid-frame aborts immediately with no partial line completed; the first post-reset pclk low phase starts on the cycle after rst_in falls.

Structure
REQ-035 Package dvp_pkg holds the state enum dvp_state_t and the default timing constants, shared with camera-side blocks.
REQ-036 One sub-module, dvp_pclk_gen (divider), generates camera_pclk_out and one-cycle fall_tick/pre_fall_tick strobes.

Verification
REQ-037 Bench parameters: H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, VS_LOW=5, PCLK_DIV=4.
- Reset then enable=1, valid=1, data = incrementing from 0x10 -> vs high for 20 pclks; 3 hs pulses of 4 pclks each; rising-edge samples 0x10..0x1B in order; frame period 25 pclks (100 clk_in).
- Same as above with an attached rising-edge receiver model -> receiver reports hcount 0..3 and vcount 0..2; no samples captured while vs=0.
- valid=0 for the 6th byte only -> byte 6 sent as 0x00, underflow_out=1 and stays 1, later bytes unshifted.
- enable=0 during line 1 -> frame completes all 3 lines plus the trailing blank, vs falls, state IDLE, pclk keeps toggling, no further frame_start_out.
- rst_in pulsed during ACTIVE -> next cycle all outputs 0, ready=0, underflow cleared; with enable=1 the next frame starts with full VS_LOW.
- Every clk_in cycle -> hs, vs, and data never change on a pclk rising-edge cycle; ready pulses exactly 12 times per frame.
